// File: rtl/riscv_checker_pkg.sv
// Shared definitions for the RISC-V result checker.
// Contents: FSM state encoding, FAIL_CODE constants and default table geometry.
package riscv_checker_pkg;

  localparam int unsigned NUM_TEST_DEF = 26;
  localparam int unsigned IDX_W_DEF    = 5;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StPass = 2'b10,
    StFail = 2'b11
  } state_e;

  typedef logic [2:0] fail_code_t;

  localparam fail_code_t FC_NONE     = 3'd0;
  localparam fail_code_t FC_MISMATCH = 3'd1;
  localparam fail_code_t FC_SKIP     = 3'd2;
  localparam fail_code_t FC_HALT     = 3'd3;
  localparam fail_code_t FC_TIMEOUT  = 3'd4;

endpackage

// File: rtl/riscv_result_checker_if.sv
// Bus between the core-side driver and the result checker.
// master: drives table load, start and the core observation signals (num_inst, output_port, halt).
// slave : the checker; drives busy/done/pass and the diagnostic outputs.
interface riscv_result_checker_if #(
  parameter int unsigned IDX_W = 5
);
  import riscv_checker_pkg::*;

  logic             tbl_we;
  logic [IDX_W-1:0] tbl_idx;
  logic [31:0]      tbl_num_inst;
  logic [31:0]      tbl_ans;
  logic             start;
  logic [31:0]      num_inst;
  logic [31:0]      output_port;
  logic             halt;

  logic             busy;
  logic             done;
  logic             pass;
  fail_code_t       fail_code;
  logic [IDX_W-1:0] fail_idx;
  logic [31:0]      fail_value;
  logic [IDX_W:0]   pass_cnt;
  logic [31:0]      cycle_cnt;

  modport master (
    output tbl_we, tbl_idx, tbl_num_inst, tbl_ans, start, num_inst, output_port, halt,
    input  busy, done, pass, fail_code, fail_idx, fail_value, pass_cnt, cycle_cnt
  );

  modport slave (
    input  tbl_we, tbl_idx, tbl_num_inst, tbl_ans, start, num_inst, output_port, halt,
    output busy, done, pass, fail_code, fail_idx, fail_value, pass_cnt, cycle_cnt
  );

endinterface

// File: rtl/riscv_checker_table.sv
// Expected-result table: NUM_TEST entries of {num_inst, answer}.
// Ports: clk; we/wr_idx/wr_num_inst/wr_ans write port (out-of-range indices dropped);
//        rd_idx with asynchronous rd_num_inst/rd_ans read data.
// The array is deliberately not reset so a loaded table survives a checker reset.
module riscv_checker_table #(
  parameter int unsigned NUM_TEST = 26,
  parameter int unsigned IDX_W    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_num_inst,
  input  logic [31:0]      wr_ans,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_num_inst,
  output logic [31:0]      rd_ans
);

  logic [63:0] mem [NUM_TEST];

  always_ff @(posedge clk) begin
    if (we && (32'(wr_idx) < NUM_TEST)) begin
      mem[wr_idx] <= {wr_num_inst, wr_ans};
    end
  end

  assign {rd_num_inst, rd_ans} = mem[rd_idx];

endmodule

// File: rtl/riscv_result_checker.sv
// Self-check monitor placed after RISCV_TOP. Walks a table of expected (num_inst, answer)
// pairs in order and reports pass/fail with diagnostics.
// Ports: clk, rst_n (async, active-low), bus (riscv_result_checker_if.slave):
//   in : tbl_we/tbl_idx/tbl_num_inst/tbl_ans, start, num_inst, output_port, halt
//   out: busy, done, pass, fail_code, fail_idx, fail_value, pass_cnt, cycle_cnt
// Optional feature: define CHECKER_TIMEOUT_EN to fail with code 4 after TIMEOUT_CYCLES in RUN.
module riscv_result_checker
  import riscv_checker_pkg::*;
#(
  parameter int unsigned NUM_TEST       = NUM_TEST_DEF,
  parameter int unsigned IDX_W          = IDX_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  rst_n,
  riscv_result_checker_if.slave bus
);

  localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(NUM_TEST - 1);
  localparam logic [IDX_W:0]   NumTestCnt = (IDX_W + 1)'(NUM_TEST);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   pass_cnt_q;
  logic [31:0]      cycle_cnt_q;
  fail_code_t       fail_code_q;
  logic [IDX_W-1:0] fail_idx_q;
  logic [31:0]      fail_value_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [31:0]      exp_num;
  logic [31:0]      exp_ans;
  logic             hit;
  logic             mismatch;
  logic             skipped;
  logic             last_hit;
  logic             early_halt;
  logic             timeout_hit;
  logic             fail_now;
  fail_code_t       fail_code_nxt;
  logic [IDX_W:0]   pass_cnt_hit;
  logic [31:0]      cycle_cnt_inc;

  riscv_checker_table #(
    .NUM_TEST (NUM_TEST),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk         (clk),
    .we          (bus.tbl_we & (state_q == StIdle)),
    .wr_idx      (bus.tbl_idx),
    .wr_num_inst (bus.tbl_num_inst),
    .wr_ans      (bus.tbl_ans),
    .rd_idx      (idx_q),
    .rd_num_inst (exp_num),
    .rd_ans      (exp_ans)
  );

  assign hit          = (bus.num_inst == exp_num) && (bus.output_port == exp_ans);
  assign mismatch     = (bus.num_inst == exp_num) && (bus.output_port != exp_ans);
  assign skipped      = bus.num_inst > exp_num;
  assign last_hit     = hit && (idx_q == LastIdx);
  assign pass_cnt_hit = pass_cnt_q + {{IDX_W{1'b0}}, hit};
  // A halt that lands on the final match is a pass, hence counting this cycle's hit.
  assign early_halt   = bus.halt && (pass_cnt_hit < NumTestCnt);
  assign cycle_cnt_inc = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;

`ifdef CHECKER_TIMEOUT_EN
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
  assign timeout_hit = (cycle_cnt_q == TimeoutLast);
`else
  // No comparator; the parameter is still referenced so both builds share one signature.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Failure priority: mismatch > skipped > (last match wins) > early halt > timeout.
  always_comb begin
    fail_now      = 1'b1;
    fail_code_nxt = FC_NONE;
    if (mismatch) begin
      fail_code_nxt = FC_MISMATCH;
    end else if (skipped) begin
      fail_code_nxt = FC_SKIP;
    end else if (last_hit) begin
      fail_now = 1'b0;
    end else if (early_halt) begin
      fail_code_nxt = FC_HALT;
    end else if (timeout_hit) begin
      fail_code_nxt = FC_TIMEOUT;
    end else begin
      fail_now = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      pass_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      fail_code_q  <= FC_NONE;
      fail_idx_q   <= '0;
      fail_value_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StPass, StFail: begin
          if (bus.start) begin
            state_q      <= StRun;
            idx_q        <= '0;
            pass_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            fail_code_q  <= FC_NONE;
            fail_idx_q   <= '0;
            fail_value_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        StRun: begin
          cycle_cnt_q <= cycle_cnt_inc;
          pass_cnt_q  <= pass_cnt_hit;
          if (fail_now) begin
            state_q      <= StFail;
            fail_code_q  <= fail_code_nxt;
            fail_idx_q   <= idx_q;
            fail_value_q <= bus.output_port;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else if (last_hit) begin
            state_q <= StPass;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (hit) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_code  = fail_code_q;
  assign bus.fail_idx   = fail_idx_q;
  assign bus.fail_value = fail_value_q;
  assign bus.pass_cnt   = pass_cnt_q;
  assign bus.cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_riscv_result_checker.sv
// Bench for riscv_result_checker: rule-level reference model compared every cycle, plus
// directed scenarios with literal expectations. Works with or without CHECKER_TIMEOUT_EN.
module tb_riscv_result_checker;

  localparam int unsigned NT = 26;
  localparam int unsigned IW = 5;
  localparam int unsigned TO = 50;
`ifdef CHECKER_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  int unsigned ans_tbl [NT] = '{0, 0, 5, 0, 1, 0, 1, 5, 5, 32'hf, 32'h1e, 32'hf, 2, 7, 2,
                                32'h14, 0, 0, 0, 32'ha, 32'ha, 32'h1e, 32'h14, 32'h64,
                                32'h28, 1};

  riscv_result_checker_if #(.IDX_W(IW)) bus ();

  riscv_result_checker #(
    .NUM_TEST       (NT),
    .IDX_W          (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 run, 2 pass, 3 fail.
  logic [31:0] m_num [NT];
  logic [31:0] m_ans [NT];
  int          m_state;
  int unsigned m_idx, m_pass, m_code, m_fidx;
  logic [31:0] m_cycle, m_fval;
  bit          m_hit;
  int          m_verdict;  // 0 continue, 1..4 fail code, 5 pass

  always_comb begin
    m_hit     = (bus.num_inst == m_num[m_idx]) && (bus.output_port == m_ans[m_idx]);
    m_verdict = 0;
    if (bus.num_inst == m_num[m_idx] && bus.output_port != m_ans[m_idx]) m_verdict = 1;
    else if (bus.num_inst > m_num[m_idx]) m_verdict = 2;
    else if (m_hit && m_idx == NT - 1) m_verdict = 5;
    else if (bus.halt && (m_pass + 32'(m_hit)) < NT) m_verdict = 3;
    else if (TimeoutOn && m_cycle == TO - 1) m_verdict = 4;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_idx <= 0; m_pass <= 0; m_code <= 0; m_fidx <= 0;
      m_cycle <= 0; m_fval <= 0;
    end else begin
      if (m_state == 0 && bus.tbl_we && bus.tbl_idx < NT) begin
        m_num[bus.tbl_idx] <= bus.tbl_num_inst;
        m_ans[bus.tbl_idx] <= bus.tbl_ans;
      end
      if (m_state != 1) begin
        if (bus.start) begin
          m_state <= 1; m_idx <= 0; m_pass <= 0; m_code <= 0; m_fidx <= 0;
          m_cycle <= 0; m_fval <= 0;
        end
      end else begin
        m_cycle <= (m_cycle == 32'hFFFF_FFFF) ? m_cycle : m_cycle + 1;
        m_pass  <= m_pass + 32'(m_hit);
        if (m_verdict >= 1 && m_verdict <= 4) begin
          m_state <= 3; m_code <= m_verdict; m_fidx <= m_idx; m_fval <= bus.output_port;
        end else if (m_verdict == 5) begin
          m_state <= 2;
        end else if (m_hit) begin
          m_idx <= m_idx + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 64'(bus.busy), 64'(m_state == 1));
      check("done", 64'(bus.done), 64'(m_state >= 2));
      check("pass", 64'(bus.pass), 64'(m_state == 2));
      check("fail_code", 64'(bus.fail_code), 64'(m_code));
      check("fail_idx", 64'(bus.fail_idx), 64'(m_fidx));
      check("fail_value", 64'(bus.fail_value), 64'(m_fval));
      check("pass_cnt", 64'(bus.pass_cnt), 64'(m_pass));
      check("cycle_cnt", 64'(bus.cycle_cnt), 64'(m_cycle));
    end
  end

  task automatic drive(input logic [31:0] num, input logic [31:0] ans, input logic halt);
    bus.num_inst    = num;
    bus.output_port = ans;
    bus.halt        = halt;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_matches(input int n);
    for (int k = 0; k < n; k++) drive(32'(k + 1), ans_tbl[k], 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 64'(bus.busy), 64'd0);
    check({tag, ".done"}, 64'(bus.done), 64'd0);
    check({tag, ".pass"}, 64'(bus.pass), 64'd0);
    check({tag, ".fail_code"}, 64'(bus.fail_code), 64'd0);
    check({tag, ".fail_idx"}, 64'(bus.fail_idx), 64'd0);
    check({tag, ".fail_value"}, 64'(bus.fail_value), 64'd0);
    check({tag, ".pass_cnt"}, 64'(bus.pass_cnt), 64'd0);
    check({tag, ".cycle_cnt"}, 64'(bus.cycle_cnt), 64'd0);
  endtask

  initial begin
    bus.tbl_we = 1'b0; bus.tbl_idx = '0; bus.tbl_num_inst = '0; bus.tbl_ans = '0;
    bus.start = 1'b0; bus.num_inst = '0; bus.output_port = '0; bus.halt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check_all_zero("reset");

    // Load table; the out-of-range writes must be dropped.
    for (int i = 0; i < 32; i++) begin
      bus.tbl_we = 1'b1; bus.tbl_idx = 5'(i);
      bus.tbl_num_inst = 32'(i + 1); bus.tbl_ans = (i < NT) ? ans_tbl[i] : 32'hBAD;
      @(negedge clk);
    end
    bus.tbl_we = 1'b0;

    // 1: full matching run, then a halt after pass is ignored.
    pulse_start();
    run_matches(NT);
    check("t1.pass", 64'(bus.pass), 64'd1);
    check("t1.pass_cnt", 64'(bus.pass_cnt), 64'd26);
    check("t1.fail_code", 64'(bus.fail_code), 64'd0);
    check("t1.cycle_cnt", 64'(bus.cycle_cnt), 64'd26);
    drive(32'd27, 32'd0, 1'b1);
    check("t1.sticky", 64'(bus.pass), 64'd1);

    // 2: wrong answer at NUM_INST=3.
    pulse_start();
    run_matches(2);
    drive(32'd3, 32'h6, 1'b0);
    check("t2.fail_code", 64'(bus.fail_code), 64'd1);
    check("t2.fail_idx", 64'(bus.fail_idx), 64'd2);
    check("t2.fail_value", 64'(bus.fail_value), 64'h6);
    check("t2.pass_cnt", 64'(bus.pass_cnt), 64'd2);

    // 3: NUM_INST jumps 4 -> 6.
    pulse_start();
    run_matches(4);
    drive(32'd6, ans_tbl[5], 1'b0);
    check("t3.fail_code", 64'(bus.fail_code), 64'd2);
    check("t3.fail_idx", 64'(bus.fail_idx), 64'd4);
    check("t3.pass_cnt", 64'(bus.pass_cnt), 64'd4);

    // 4a: halt after 10 matches.
    pulse_start();
    run_matches(10);
    drive(32'd10, ans_tbl[9], 1'b1);
    check("t4.fail_code", 64'(bus.fail_code), 64'd3);
    check("t4.pass_cnt", 64'(bus.pass_cnt), 64'd10);
    check("t4.fail_idx", 64'(bus.fail_idx), 64'd10);

    // 4b: halt coincident with the last match is a pass.
    pulse_start();
    run_matches(NT - 1);
    drive(32'd26, ans_tbl[25], 1'b1);
    check("t4b.pass", 64'(bus.pass), 64'd1);
    check("t4b.pass_cnt", 64'(bus.pass_cnt), 64'd26);
    check("t4b.fail_code", 64'(bus.fail_code), 64'd0);

    // 5: NUM_INST stuck at 0.
    pulse_start();
`ifdef CHECKER_TIMEOUT_EN
    repeat (TO - 1) drive(32'd0, 32'd0, 1'b0);
    check("t5.busy_before", 64'(bus.busy), 64'd1);
    drive(32'd0, 32'd0, 1'b0);
    check("t5.fail_code", 64'(bus.fail_code), 64'd4);
    check("t5.cycle_cnt", 64'(bus.cycle_cnt), 64'd50);
    check("t5.done", 64'(bus.done), 64'd1);
`else
    repeat (TO + 10) drive(32'd0, 32'd0, 1'b0);
    check("t5.busy", 64'(bus.busy), 64'd1);
    check("t5.cycle_cnt", 64'(bus.cycle_cnt), 64'd60);
    check("t5.fail_code", 64'(bus.fail_code), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // 6: reset mid-run, then rerun on the retained table with writes and start in RUN.
    pulse_start();
    run_matches(7);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6.reset");
    #1 rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int k = 0; k < NT; k++) begin
      bus.tbl_we = 1'b1; bus.tbl_idx = 5'(k); bus.tbl_num_inst = 32'd99;
      bus.tbl_ans = 32'hDEAD;
      bus.start = (k == 5);
      drive(32'(k + 1), ans_tbl[k], 1'b0);
    end
    bus.tbl_we = 1'b0; bus.start = 1'b0;
    check("t6.pass", 64'(bus.pass), 64'd1);
    check("t6.pass_cnt", 64'(bus.pass_cnt), 64'd26);
    check("t6.cycle_cnt", 64'(bus.cycle_cnt), 64'd26);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_result_checker.md
Name: riscv_result_checker

Overview:
Synthesizable self-check monitor placed directly downstream of RISCV_TOP. It consumes the core's NUM_INST, OUTPUT_PORT and HALT outputs. It compares OUTPUT_PORT against a loadable table of expected (instruction-count, answer) pairs, in order, and reports pass/fail status with diagnostics. This lets on-board and gate-level runs be checked without a behavioural testbench.

Parameters:
NUM_TEST, 26, number of table entries (1..32)
IDX_W, 5, index width; 2**IDX_W >= NUM_TEST
TIMEOUT_CYCLES, 1000, cycles in RUN before a timeout failure (used only with CHECKER_TIMEOUT_EN)

Ports:
CLK  input  1  core clock
RSTn  input  1  reset; asynchronous assert, active-low
TBL_WE  input  1  table write strobe; honoured only in IDLE
TBL_IDX  input  IDX_W  table write index; writes with index >= NUM_TEST ignored
TBL_NUM_INST  input  32  expected NUM_INST for the entry
TBL_ANS  input  32  expected OUTPUT_PORT for the entry
START  input  1  one-cycle pulse; starts checking
NUM_INST  input  32  retired-instruction count from core
OUTPUT_PORT  input  32  result port from core
HALT  input  1  core halt flag
BUSY  output  1  high in RUN
DONE  output  1  high in PASS or FAIL
PASS  output  1  high in PASS
FAIL_CODE  output  3  0 none, 1 mismatch, 2 skipped, 3 early halt, 4 timeout
FAIL_IDX  output  IDX_W  table index at which failure occurred
FAIL_VALUE  output  32  OUTPUT_PORT captured at failure
PASS_CNT  output  IDX_W+1  entries passed so far
CYCLE_CNT  output  32  cycles spent in RUN, saturating at 0xFFFFFFFF

Behaviour:
- Reset (RSTn low, asynchronous): state=IDLE. All outputs 0, idx=0. Table contents are not reset.
- States: IDLE, RUN, PASS, FAIL. Encoding is fixed in the package.
- IDLE: TBL_WE writes the entry on the clock edge. START -> RUN next cycle; idx, PASS_CNT and CYCLE_CNT clear; FAIL_* clear.
- RUN: each cycle CYCLE_CNT+1. Compare against entry[idx] using registered status with 1-cycle latency; inputs are sampled on edge N and status is visible after edge N.
  - NUM_INST == exp_num[idx] and OUTPUT_PORT == exp_ans[idx]: idx+1, PASS_CNT+1.
  - NUM_INST == exp_num[idx] with a different answer: FAIL, code 1.
  - NUM_INST > exp_num[idx] (unsigned): FAIL, code 2 (entry skipped).
  - HALT with PASS_CNT+match < NUM_TEST: FAIL, code 3.
  - Last entry matched (idx==NUM_TEST-1): PASS, whether or not HALT is high. HALT after PASS is ignored.
  - Timeout: CYCLE_CNT reaches TIMEOUT_CYCLES-1 -> FAIL, code 4.
- Priority in the same cycle: mismatch > skipped > last-match PASS > early halt > timeout. Last match together with HALT gives PASS.
- On entry to FAIL: FAIL_IDX=idx and FAIL_VALUE=OUTPUT_PORT, both latched.
- PASS/FAIL are sticky. START returns to RUN with counters cleared. TBL_WE is ignored outside IDLE. START in RUN is ignored.
- Reset mid-RUN: immediate return to IDLE. The table is retained, so a START without reloading reruns the same table.
- idx never exceeds NUM_TEST-1. PASS_CNT max is NUM_TEST.

Optional Feature:
CHECKER_TIMEOUT_EN
- Defined: timeout detection per above, using TIMEOUT_CYCLES.
- Undefined: no timeout. FAIL_CODE 4 is never produced. The CYCLE_CNT comparator is removed; CYCLE_CNT still counts and saturates.

Decomposition:
- riscv_checker_pkg: state encoding, FAIL_CODE constants (FC_NONE, FC_MISMATCH, FC_SKIP, FC_HALT, FC_TIMEOUT), default NUM_TEST/IDX_W.
- Sub-module riscv_checker_table: NUM_TEST x 64-bit register array.
  - One write port and one asynchronous read port indexed by idx.
  - The FSM, counters and priority logic stay in riscv_result_checker.

Test Plan:
1. Load 26 entries (NUM_INST 1..26, answers 0,0,5,0,1,0,1,5,5,0xf,0x1e,0xf,2,7,2,0x14,0,0,0,0xa,0xa,0x1e,0x14,0x64,0x28,1), START, drive matching sequence -> PASS=1, PASS_CNT=26, FAIL_CODE=0.
2. Same table, OUTPUT_PORT=0x6 at NUM_INST=3 -> FAIL, FAIL_CODE=1, FAIL_IDX=2, FAIL_VALUE=0x6, PASS_CNT=2.
3. NUM_INST jumps 4->6 -> FAIL_CODE=2, FAIL_IDX=4.
4. HALT asserted at NUM_INST=10 after 10 matches -> FAIL_CODE=3, PASS_CNT=10. Separately, HALT together with the 26th match -> PASS.
5. CHECKER_TIMEOUT_EN, TIMEOUT_CYCLES=50, NUM_INST held at 0 -> FAIL_CODE=4 after 50 RUN cycles, CYCLE_CNT=50. Without the macro -> BUSY stays 1.
6. RSTn low for 1 ns mid-RUN (idx=7) -> all outputs 0 immediately. START then rerun -> PASS with the retained table. TBL_WE in RUN does not alter results.
